// File: rtl/bcd_to_decimal_decoder_fifo.sv
// BCD digit decoder with a valid/ready input, a small FIFO of one-hot decimal results,
// and a saturating count of illegal (10..15) codes.
module bcd_to_decimal_decoder_fifo #(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_bcd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [9:0]                 out_dec,
    output logic                       out_err,
    output logic [ERR_W-1:0]           err_count,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [9:0]       dec_mem [DEPTH];
    logic             err_mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [9:0]       dec_onehot;
    logic             code_illegal;
    logic             push;
    logic             pop;

    // One comparator per decimal digit; codes 10..15 leave every bit clear.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_decode
            assign dec_onehot[gi] = (in_bcd == 4'(gi));
        end
    endgenerate

    assign code_illegal = (in_bcd > 4'd9);

    // Readiness depends only on the stored level, never on out_ready.
    assign in_ready  = rst_n && !clear && (level_q < FULL_LEVEL);
    assign out_valid = (level_q != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready && rst_n && !clear;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (code_illegal && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            dec_mem[wr_ptr_q] <= dec_onehot;
            err_mem[wr_ptr_q] <= code_illegal;
        end
    end

    assign out_dec    = out_valid ? dec_mem[rd_ptr_q] : 10'd0;
    assign out_err    = out_valid ? err_mem[rd_ptr_q] : 1'b0;
    assign err_count  = err_cnt_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_bcd_to_decimal_decoder_fifo.sv
// Directed bench for the BCD decoder FIFO: a vector table for the streaming decode
// plus hand-written sequences for backpressure, ordering, saturation and flush.
module tb_bcd_to_decimal_decoder_fifo;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_bcd;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_dec;
    logic       out_err;
    logic [7:0] err_count;
    logic [2:0] fifo_level;

    // Narrow-counter instance used for the saturation check.
    logic       in_valid2;
    logic       in_ready2;
    logic [3:0] in_bcd2;
    logic       out_valid2;
    logic       out_ready2;
    logic [9:0] out_dec2;
    logic       out_err2;
    logic [1:0] err_count2;
    logic [2:0] fifo_level2;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_to_decimal_decoder_fifo #(.DEPTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_dec(out_dec),
        .out_err(out_err), .err_count(err_count), .fifo_level(fifo_level)
    );

    bcd_to_decimal_decoder_fifo #(.DEPTH(4), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_bcd(in_bcd2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_dec(out_dec2),
        .out_err(out_err2), .err_count(err_count2), .fifo_level(fifo_level2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bcd;
        logic [9:0] dec;
        logic       err;
        int         cnt;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_hold(input logic [3:0] code);
        in_valid  = 1'b1;
        in_bcd    = code;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd0,  10'h001, 1'b0, 0};
        vecs[1]  = '{4'd1,  10'h002, 1'b0, 0};
        vecs[2]  = '{4'd2,  10'h004, 1'b0, 0};
        vecs[3]  = '{4'd3,  10'h008, 1'b0, 0};
        vecs[4]  = '{4'd4,  10'h010, 1'b0, 0};
        vecs[5]  = '{4'd5,  10'h020, 1'b0, 0};
        vecs[6]  = '{4'd6,  10'h040, 1'b0, 0};
        vecs[7]  = '{4'd7,  10'h080, 1'b0, 0};
        vecs[8]  = '{4'd8,  10'h100, 1'b0, 0};
        vecs[9]  = '{4'd9,  10'h200, 1'b0, 0};
        vecs[10] = '{4'd10, 10'h000, 1'b1, 1};
        vecs[11] = '{4'd11, 10'h000, 1'b1, 2};
        vecs[12] = '{4'd12, 10'h000, 1'b1, 3};
        vecs[13] = '{4'd13, 10'h000, 1'b1, 4};
        vecs[14] = '{4'd14, 10'h000, 1'b1, 5};
        vecs[15] = '{4'd15, 10'h000, 1'b1, 6};

        rst_n = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_bcd = 4'd0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_bcd2 = 4'd0; out_ready2 = 1'b1;

        // Reset state
        step(); step();
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst level", 32'(fifo_level), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_dec", 32'(out_dec), 32'd0);
        check("rst out_err", 32'(out_err), 32'd0);
        check("rst err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);

        // Streaming decode table, one push per cycle with the consumer always ready
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_bcd    = vecs[i].bcd;
            out_ready = 1'b1;
            step();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d out_dec", i), 32'(out_dec), 32'(vecs[i].dec));
            check($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vecs[i].err));
            check($sformatf("vec%0d err_count", i), 32'(err_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d level", i), 32'(fifo_level), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain level", 32'(fifo_level), 32'd0);
        check("drain out_dec", 32'(out_dec), 32'd0);

        // Fill to full with consumer stalled; a push during the first pop is refused
        clear = 1'b1; step(); clear = 1'b0;
        check("clear err_count", 32'(err_count), 32'd0);
        push_hold(4'd3); push_hold(4'd5); push_hold(4'd7); push_hold(4'd9);
        check("full level", 32'(fifo_level), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_bcd = 4'd1; out_ready = 1'b0;
        step();
        check("held level", 32'(fifo_level), 32'd4);
        check("held head", 32'(out_dec), 32'h008);
        out_ready = 1'b1;
        check("pop0 head", 32'(out_dec), 32'h008);
        step();
        in_valid = 1'b0;
        check("pop+push-full level", 32'(fifo_level), 32'd3);
        check("pop1 head", 32'(out_dec), 32'h020);
        step();
        check("pop2 head", 32'(out_dec), 32'h080);
        step();
        check("pop3 head", 32'(out_dec), 32'h200);
        step();
        check("emptied out_valid", 32'(out_valid), 32'd0);
        check("emptied level", 32'(fifo_level), 32'd0);

        // Illegal code followed by a legal one
        push_hold(4'd12); push_hold(4'd4);
        check("err head dec", 32'(out_dec), 32'h000);
        check("err head err", 32'(out_err), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("after err dec", 32'(out_dec), 32'h010);
        check("after err err", 32'(out_err), 32'd0);
        check("after err count", 32'(err_count), 32'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Saturation on the 2-bit counter instance
        in_valid2 = 1'b1; in_bcd2 = 4'd15;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sat push%0d", i), 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        in_valid2 = 1'b0;

        // Push and pop on the same edge at level 2
        push_hold(4'd1); push_hold(4'd2);
        in_valid = 1'b1; in_bcd = 4'd6; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("pushpop level", 32'(fifo_level), 32'd2);
        check("pushpop head", 32'(out_dec), 32'h004);
        step();
        check("pushpop tail", 32'(out_dec), 32'h040);
        step();
        check("pushpop empty", 32'(fifo_level), 32'd0);

        // Flush by clear with a push pending
        push_hold(4'd1); push_hold(4'd11); push_hold(4'd3);
        check("pre-clear level", 32'(fifo_level), 32'd3);
        check("pre-clear errs", 32'(err_count), 32'd2);
        clear = 1'b1; in_valid = 1'b1; in_bcd = 4'd5; out_ready = 1'b1;
        #1;
        check("clear in_ready", 32'(in_ready), 32'd0);
        step();
        clear = 1'b0; in_valid = 1'b0;
        check("clear level", 32'(fifo_level), 32'd0);
        check("clear out_valid", 32'(out_valid), 32'd0);
        check("clear err_count", 32'(err_count), 32'd0);
        step();
        check("post-clear level", 32'(fifo_level), 32'd0);

        // Flush by reset mid-stream
        push_hold(4'd2); push_hold(4'd13); push_hold(4'd8);
        rst_n = 1'b0; in_valid = 1'b1; in_bcd = 4'd5;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        check("reset level", 32'(fifo_level), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        step();
        check("post-reset out_dec", 32'(out_dec), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
